conv_layer_sequencer: RTL
=========================

CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd16_000_000, meaning per-layer watchdog limit in i_clk cycles.
REQ-002 SHALL have parameter DESC_WORDS, default 12, meaning descriptor words per layer.
REQ-003 i_clk  input  1  clock; all state changes on the rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-low.
REQ-005 i_go  input  1  single-cycle request to run a layer chain; ignored while o_busy=1.
REQ-006 i_abort  input  1  stops the chain.
REQ-007 i_num_layers  input  5  number of layers to run; 0..16, values above 16 are treated as 16.
REQ-008 o_desc_addr  output  8  descriptor memory read address; 1-cycle read latency.
REQ-009 i_desc_data  input  32  descriptor memory read data.
REQ-010 o_cm_addr / o_cm_we / o_cm_wdata  output  4/1/32  control-memory port: address, write enable, write data.
REQ-011 i_cm_rdata  input  32  control-memory read data; 1-cycle latency.
REQ-012 o_busy  output  1  chain in progress.
REQ-013 o_done  output  1  1-cycle pulse when the chain completes.
REQ-014 o_err  output  1  sticky watchdog-timeout flag.
REQ-015 o_cur_layer  output  4  index of the layer being executed.

Function
REQ-016 Control-memory map SHALL be: addr0 CTRL {cur_layer[8:5], maxpool[4], bn[3], conv[2], done[1], start[0]}; addr2 PARAM1; addr3 PARAM2; addr4..12 kernel K0..K8 in bits [15:0].
REQ-017 Layer L descriptor SHALL start at base L*12; offsets are 0 PARAM1, 1 PARAM2, 2..10 K0..K8, 11 flags (bits [4:2] = maxpool, bn, conv).
REQ-018 FSM states SHALL be IDLE, LOAD, KICK, WAIT, NEXT, ABORT.
REQ-019 IDLE -> LOAD on i_go with i_num_layers>0; on i_go with i_num_layers=0, o_done SHALL pulse the next cycle with no memory writes.
REQ-020 LOAD SHALL issue descriptor offsets 0..11 on consecutive cycles. Each word returns one cycle after issue; offsets 0..10 SHALL be written to cm addr 2..12, and the flags word SHALL be latched. LOAD lasts 13 cycles.
REQ-021 KICK SHALL perform a single write to cm addr0 of {23'b0, layer, flags[4:2], 1'b0, 1'b1}, then enter WAIT.
REQ-022 WAIT SHALL hold o_cm_addr=0 with o_cm_we=0, ignore i_cm_rdata for the first 2 cycles, then exit when i_cm_rdata[1]=1.
REQ-023 NEXT SHALL increment the layer index. It SHALL return to LOAD when layers remain; otherwise it SHALL go to IDLE and pulse o_done.
REQ-024 Watchdog: a counter SHALL clear on entry to WAIT. If it reaches TIMEOUT_CYCLES, the block SHALL set o_err, write CTRL=0, and go to IDLE without pulsing o_done.
REQ-025 i_abort in any non-IDLE state SHALL enter ABORT, write CTRL=0 for one cycle, then go to IDLE without pulsing o_done. i_abort has priority over a same-cycle done or timeout.
REQ-026 o_err SHALL clear on an accepted i_go.
REQ-027 o_busy SHALL be 1 from the cycle after an accepted i_go through the final NEXT/ABORT cycle.
REQ-028 The 4-bit layer index SHALL not wrap, because the chain ends at 16 layers.

Reset
REQ-029 While i_rst=0, the FSM SHALL be IDLE and all outputs, counters, and latched flags SHALL be 0; o_cm_we=0 is guaranteed immediately.
REQ-030 Reset mid-chain SHALL abandon the chain with no further memory writes.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the CTRL/PARAM1/PARAM2/KERNEL0 addresses, the CTRL bit positions, and DESC_WORDS.
REQ-032 The watchdog SHALL be one sub-module, seq_watchdog (inputs clear and enable; output expired).

Verification
REQ-033 i_num_layers=1, desc word0=0x0000_3434 -> cm addr2 written 0x3434, addr12 written K8, then addr0 written 0x0000_0005 (conv flag set); model sets done 40 cycles later -> o_done pulse, o_busy falls.
REQ-034 i_num_layers=3 -> descriptor reads at bases 0, 12, 24; CTRL writes carry cur_layer 0, 1, 2 (0x005, 0x025, 0x045 with conv set); exactly one o_done.
REQ-035 i_num_layers=0 -> o_done the next cycle, zero writes.
REQ-036 TIMEOUT_CYCLES=100 with the done bit never set -> o_err=1 at WAIT cycle 100, CTRL=0 written, no o_done; the next i_go clears o_err.
REQ-037 i_abort in LOAD cycle 5 -> single write of CTRL=0, then IDLE; i_go issued while busy has no effect.
REQ-038 i_rst low during WAIT -> all outputs 0 immediately; after release, the block is IDLE.

Source files
------------

// File: rtl/conv_layer_sequencer_pkg.sv
// Shared definitions for the conv layer sequencer: FSM encoding, control-memory map, descriptor layout.
// No logic here; the helpers are combinational with zero latency.
package conv_layer_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_WAIT,
    ST_NEXT,
    ST_ABORT
  } state_e;

  localparam logic [3:0] CM_CTRL    = 4'd0;
  localparam logic [3:0] CM_PARAM1  = 4'd2;
  localparam logic [3:0] CM_PARAM2  = 4'd3;
  localparam logic [3:0] CM_KERNEL0 = 4'd4;

  localparam int CTRL_START     = 0;
  localparam int CTRL_DONE      = 1;
  localparam int CTRL_CONV      = 2;
  localparam int CTRL_BN        = 3;
  localparam int CTRL_MAXPOOL   = 4;
  localparam int CTRL_LAYER_LSB = 5;

  localparam int DESC_WORDS = 12;
  localparam int MAX_LAYERS = 16;

  // Descriptor offset -> control-memory destination (PARAM1, PARAM2, then kernel taps).
  function automatic logic [3:0] desc_dest(input logic [3:0] off);
    case (off)
      4'd0:    return CM_PARAM1;
      4'd1:    return CM_PARAM2;
      default: return CM_KERNEL0 + off - 4'd2;
    endcase
  endfunction

  // flags = {maxpool, bn, conv} as taken from descriptor bits [4:2].
  function automatic logic [31:0] ctrl_word(input logic [3:0] layer, input logic [2:0] flags);
    logic [31:0] w;
    w = '0;
    w[CTRL_LAYER_LSB +: 4] = layer;
    w[CTRL_CONV]           = flags[0];
    w[CTRL_BN]             = flags[1];
    w[CTRL_MAXPOOL]        = flags[2];
    w[CTRL_START]          = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/conv_layer_sequencer_watchdog.sv
// Per-layer watchdog: counts enabled cycles since the last clear, saturating at the limit.
// expired_o is combinational and asserts during the LIMIT-th enabled cycle.
module seq_watchdog #(
  parameter logic [23:0] LIMIT = 24'd16_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [23:0] cnt_q, cnt_d;
  logic        at_limit;

  assign at_limit  = (cnt_q == LIMIT - 24'd1);
  assign expired_o = enable_i && at_limit;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !at_limit) begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Layer-chain sequencer: copies each layer descriptor into control memory, kicks the accelerator, waits for done.
// About DESC_WORDS+3 cycles per layer plus accelerator time; no backpressure, i_go ignored while busy.
module conv_layer_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd16_000_000,
  parameter int          DESC_WORDS     = conv_layer_sequencer_pkg::DESC_WORDS
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_go,
  input  logic        i_abort,
  input  logic [4:0]  i_num_layers,
  output logic [7:0]  o_desc_addr,
  input  logic [31:0] i_desc_data,
  output logic [3:0]  o_cm_addr,
  output logic        o_cm_we,
  output logic [31:0] o_cm_wdata,
  input  logic [31:0] i_cm_rdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [3:0]  o_cur_layer
);
  import conv_layer_sequencer_pkg::*;

  localparam int            CW   = $clog2(DESC_WORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(DESC_WORDS);
  localparam logic [7:0]    DW8  = 8'(DESC_WORDS);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    layer_q, layer_d;
  logic [4:0]    nl_q, nl_d;
  logic [2:0]    flags_q, flags_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          wd_expired;
  logic          unused_rdata;

  assign unused_rdata = ^{i_cm_rdata[31:2], i_cm_rdata[0]};

  seq_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .clear_i  (state_q != ST_WAIT),
    .enable_i (state_q == ST_WAIT),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    layer_d     = layer_q;
    nl_d        = nl_q;
    flags_d     = flags_q;
    done_d      = 1'b0;
    err_d       = err_q;
    o_desc_addr = '0;
    o_cm_addr   = '0;
    o_cm_we     = 1'b0;
    o_cm_wdata  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_go) begin
          err_d   = 1'b0;
          layer_d = '0;
          nl_d    = (i_num_layers > 5'(MAX_LAYERS)) ? 5'(MAX_LAYERS) : i_num_layers;
          if (i_num_layers == 5'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      // Read issued at cnt k returns at cnt k+1; the last word is the flags word.
      ST_LOAD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q < LAST) begin
          o_desc_addr = DW8 * {4'b0, layer_q} + 8'(cnt_q);
        end
        if (cnt_q != '0 && cnt_q < LAST) begin
          o_cm_we    = 1'b1;
          o_cm_addr  = desc_dest(4'(cnt_q - CW'(1)));
          o_cm_wdata = i_desc_data;
        end
        if (cnt_q == LAST) begin
          flags_d = i_desc_data[4:2];
          state_d = ST_KICK;
        end
      end
      ST_KICK: begin
        o_cm_we    = 1'b1;
        o_cm_addr  = CM_CTRL;
        o_cm_wdata = ctrl_word(layer_q, flags_q);
        state_d    = ST_WAIT;
      end
      // First two WAIT cycles may still see the status read from before the kick.
      ST_WAIT: begin
        o_cm_addr = CM_CTRL;
        cnt_d     = (cnt_q == CW'(2)) ? cnt_q : cnt_q + CW'(1);
        if (cnt_q == CW'(2) && i_cm_rdata[CTRL_DONE]) begin
          state_d = ST_NEXT;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          o_cm_we = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_NEXT: begin
        if (({1'b0, layer_q} + 5'd1) < nl_q) begin
          layer_d = layer_q + 4'd1;
          state_d = ST_LOAD;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ABORT: begin
        o_cm_we   = 1'b1;
        o_cm_addr = CM_CTRL;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over any same-cycle write, done or timeout.
    if (i_abort && state_q != ST_IDLE && state_q != ST_ABORT) begin
      state_d = ST_ABORT;
      o_cm_we = 1'b0;
      cnt_d   = '0;
      layer_d = layer_q;
      flags_d = flags_q;
      done_d  = 1'b0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      layer_q <= '0;
      nl_q    <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      layer_q <= layer_d;
      nl_q    <= nl_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_cur_layer = layer_q;

endmodule
